weight_load_sched: RTL and testbench



---
 rtl/weight_load_sched.sv | 174 +++++++++++++++++
 tb/tb_weight_load_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_sched.sv
// weight_load_sched
//   Queued scheduler for the NPU weight-RAM write port. Load descriptors
//   {mem, len} are queued in a small FIFO; each one steers the next
//   AXI-Stream packet into RAM 'mem' at rows 0..len-1. It flags beat-count
//   and TLAST disagreement, and pulses 'done' once per descriptor.
//
//   Optional feature: define WLS_BEAT_COUNT_EN to build a saturating 32-bit
//   count of RAM writes on beat_total; otherwise beat_total is tied to 0.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   cmd_valid/ready     descriptor push handshake (ready = FIFO not full)
//   cmd_mem, cmd_len    target RAM index, beat count (0 = no-op)
//   s_tdata/tvalid/tlast/tready   weight stream slave
//   ram_din, ram_reg_adr, ram_mem_adr, ram_we   registered RAM write port
//   busy                block active or descriptors pending
//   done                one-cycle pulse per completed descriptor
//   err                 sticky length/TLAST mismatch
//   beat_total          total beats written (see WLS_BEAT_COUNT_EN)
module weight_load_sched #(
   parameter int DATA_WIDTH = 64,
   parameter int ADR_WIDTH  = 12,
   parameter int MEM_BITS   = 3,
   parameter int QDEPTH     = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [MEM_BITS-1:0]   cmd_mem,
   input  logic [ADR_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic [ADR_WIDTH-1:0]  ram_reg_adr,
   output logic [MEM_BITS-1:0]   ram_mem_adr,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           beat_total
);

   localparam int PW = $clog2(QDEPTH);

   typedef struct packed {
      logic [MEM_BITS-1:0]  mem;
      logic [ADR_WIDTH-1:0] len;
   } desc_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   state_t               state_q, state_d;
   desc_t                fifo_q [QDEPTH];
   desc_t                head;
   logic [PW:0]          wr_ptr, rd_ptr;
   logic                 full, empty, push, pop;
   logic [MEM_BITS-1:0]  cur_mem;
   logic [ADR_WIDTH-1:0] cur_len, cnt;
   logic                 is_last, beat, fin, mismatch, done_d;

   // ---------------- descriptor FIFO ----------------
   // Pointers carry one extra wrap bit so full/empty need no counter.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign cmd_ready = !full;
   // Full is judged before any same-cycle pop, so a pop never frees room early.
   assign push      = cmd_valid && !full;
   assign head      = fifo_q[rd_ptr[PW-1:0]];

   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_ptr[PW-1:0]] <= '{mem: cmd_mem, len: cmd_len};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // ---------------- control FSM ----------------
   // len-1 wraps at ADR_WIDTH, so only len==0 is special and it never reaches LOAD.
   assign is_last = (cnt == cur_len - ADR_WIDTH'(1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      s_tready = 1'b0;
      pop      = 1'b0;
      beat     = 1'b0;
      fin      = 1'b0;
      mismatch = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head.len != '0) state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               beat = 1'b1;
               // Either the count or TLAST ends the descriptor; a short
               // packet's last beat is still written.
               if (is_last || s_tlast) begin
                  fin      = 1'b1;
                  mismatch = (is_last != s_tlast);
                  state_d  = (is_last && !s_tlast) ? S_DRAIN : S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign done_d = fin || (pop && head.len == '0);
   assign busy   = (state_q != S_IDLE) || !empty;

   // ---------------- datapath / registered outputs ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cur_mem     <= '0;
         cur_len     <= '0;
         cnt         <= '0;
         ram_din     <= '0;
         ram_reg_adr <= '0;
         ram_mem_adr <= '0;
         ram_we      <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         ram_we <= beat;
         done   <= done_d;
         if (mismatch) err <= 1'b1;
         if (pop) begin
            cur_mem <= head.mem;
            cur_len <= head.len;
            cnt     <= '0;
         end
         // Address/data only move on a write so they hold between beats.
         if (beat) begin
            ram_din     <= s_tdata;
            ram_reg_adr <= cnt;
            ram_mem_adr <= cur_mem;
            cnt         <= cnt + ADR_WIDTH'(1);
         end
      end
   end

`ifdef WLS_BEAT_COUNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                        beat_total <= '0;
      else if (ram_we && beat_total != '1) beat_total <= beat_total + 32'd1;
   end
`else
   assign beat_total = '0;
`endif

endmodule

// File: tb/tb_weight_load_sched.sv
// Self-checking bench for weight_load_sched: table-driven vectors, hand
// sequences for latency / FIFO-full / async reset, and a randomized run
// checked against a per-descriptor reference model.
module tb_weight_load_sched;
   localparam int DW = 64, AW = 12, MB = 3, QD = 4;
   localparam int LIMIT = 10000;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          cmd_valid, cmd_ready;
   logic [MB-1:0] cmd_mem;
   logic [AW-1:0] cmd_len;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic [DW-1:0] ram_din;
   logic [AW-1:0] ram_reg_adr;
   logic [MB-1:0] ram_mem_adr;
   logic          ram_we, busy, done, err;
   logic [31:0]   beat_total;

   always #5 CLK = ~CLK;

   weight_load_sched #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .MEM_BITS(MB), .QDEPTH(QD)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mem(cmd_mem), .cmd_len(cmd_len),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .ram_din(ram_din), .ram_reg_adr(ram_reg_adr), .ram_mem_adr(ram_mem_adr), .ram_we(ram_we),
      .busy(busy), .done(done), .err(err), .beat_total(beat_total)
   );

   typedef struct { logic [MB-1:0] mem; logic [AW-1:0] len; } cmd_t;
   typedef struct { logic [DW-1:0] data; logic last; } beat_t;
   typedef struct { logic [MB-1:0] mem; logic [AW-1:0] row; logic [DW-1:0] data; } wr_t;
   typedef struct { logic [MB-1:0] mem; int len; int nbeats; int exp_wr; logic exp_err; } vec_t;

   cmd_t  cmdq[$];
   beat_t beatq[$];
   wr_t   expq[$];
   wr_t   gotq[$];
   int    exp_done, got_done, exp_total;
   logic  exp_err;
   int    checks = 0, errors = 0;
   int    stall_pct = 0;
   vec_t  tbl[7];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic clear_model();
      cmdq.delete(); beatq.delete(); expq.delete(); gotq.delete();
      exp_done = 0; got_done = 0; exp_total = 0; exp_err = 1'b0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      cmd_valid = 1'b0; cmd_mem = '0; cmd_len = '0;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      clear_model();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_s_tready"}, s_tready, 0);
      chk({tag, "_ram_we_done_err_busy"}, {ram_we, done, err, busy}, 0);
      chk({tag, "_ram_din"}, ram_din, 0);
      chk({tag, "_ram_adr"}, {ram_mem_adr, ram_reg_adr}, 0);
      chk({tag, "_beat_total"}, beat_total, 0);
   endtask

   // Reference model: each descriptor with len>0 consumes exactly one packet
   // of n beats; rows 0..min(len,n)-1 are written, and n!=len is an error.
   task automatic add_job(input logic [MB-1:0] mem, input int len, input int n);
      logic [DW-1:0] d;
      cmdq.push_back('{mem, AW'(len)});
      exp_done++;
      if (len != 0) begin
         for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            beatq.push_back('{d, (i == n - 1)});
            if (i < len) begin
               expq.push_back('{mem, AW'(i), d});
               exp_total++;
            end
         end
         if (n != len) exp_err = 1'b1;
      end
   endtask

   task automatic sample();
      if (ram_we) gotq.push_back('{ram_mem_adr, ram_reg_adr, ram_din});
      if (done) got_done++;
   endtask

   // One cycle: observe outputs of the last edge, then present inputs for the
   // next edge. Readies depend only on DUT state, so handshakes are known now.
   task automatic cycle();
      @(negedge CLK);
      sample();
      cmd_valid = (cmdq.size() > 0) && ($urandom_range(99) >= stall_pct);
      if (cmd_valid) begin cmd_mem = cmdq[0].mem; cmd_len = cmdq[0].len; end
      s_tvalid = (beatq.size() > 0) && ($urandom_range(99) >= stall_pct);
      if (s_tvalid) begin s_tdata = beatq[0].data; s_tlast = beatq[0].last; end
      if (cmd_valid && cmd_ready) void'(cmdq.pop_front());
      if (s_tvalid && s_tready) void'(beatq.pop_front());
   endtask

   task automatic run(input string nm);
      int cyc = 0, idle = 0;
      while (idle < 3 && cyc < LIMIT) begin
         cycle();
         cyc++;
         if (cmdq.size() == 0 && beatq.size() == 0 && !busy) idle++;
         else idle = 0;
      end
      chk({nm, "_timeout"}, (cyc < LIMIT), 1);
      chk({nm, "_wr_count"}, gotq.size(), expq.size());
      for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
         chk({nm, "_wr_adr"}, {gotq[i].mem, gotq[i].row}, {expq[i].mem, expq[i].row});
         chk({nm, "_wr_data"}, gotq[i].data, expq[i].data);
      end
      chk({nm, "_done_count"}, got_done, exp_done);
`ifdef WLS_BEAT_COUNT_EN
      chk({nm, "_beat_total"}, beat_total, exp_total);
`else
      chk({nm, "_beat_total"}, beat_total, 0);
`endif
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int acc;
      // {mem, len, beats streamed, rows expected written, err expected}
      tbl[0] = '{3'd2, 3,    3,    3,    1'b0};   // exact packet
      tbl[1] = '{3'd1, 2,    4,    2,    1'b1};   // long packet, drained
      tbl[2] = '{3'd5, 4,    2,    2,    1'b1};   // short packet
      tbl[3] = '{3'd0, 0,    0,    0,    1'b0};   // no-op descriptor
      tbl[4] = '{3'd7, 1,    1,    1,    1'b0};   // single beat
      tbl[5] = '{3'd3, 5,    6,    5,    1'b1};   // one extra beat
      tbl[6] = '{3'd6, 4095, 4095, 4095, 1'b0};   // maximum length

      do_reset();
      #1;
      check_reset_vals("reset");

      // ---- table vectors, each from reset ----
      foreach (tbl[v]) begin
         do_reset();
         add_job(tbl[v].mem, tbl[v].len, tbl[v].nbeats);
         run($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_tbl_writes", v), gotq.size(), tbl[v].exp_wr);
         chk($sformatf("vec%0d_err", v), err, tbl[v].exp_err);
      end

      // ---- short packet followed by a clean descriptor ----
      do_reset();
      add_job(3'd5, 4, 2);
      add_job(3'd4, 3, 3);
      run("short_then_clean");
      chk("short_then_clean_err", err, 1);

      // ---- latency, no-op then single write ----
      do_reset();
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_mem = 3'd0; cmd_len = '0;
      @(negedge CLK);
      cmd_mem = 3'd3; cmd_len = AW'(1);
      chk("lat_tready_early", s_tready, 0);
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("noop_done", {done, ram_we}, 2'b10);
      @(negedge CLK);
      chk("lat_tready_2cyc", s_tready, 1);
      chk("noop_done_pulse", done, 0);
      d = {$urandom, $urandom};
      s_tvalid = 1'b1; s_tdata = d; s_tlast = 1'b1;
      @(negedge CLK);
      s_tvalid = 1'b0;
      chk("single_we_done", {ram_we, done, err}, 3'b110);
      chk("single_adr", {ram_mem_adr, ram_reg_adr}, {3'd3, 12'd0});
      chk("single_data", ram_din, d);
      @(negedge CLK);
      chk("single_after", {ram_we, done, s_tready, busy}, 0);
      chk("single_hold", ram_din, d);

      // ---- FIFO full while stream stalled ----
      // The first descriptor pops on the cycle after its push, so QD+1
      // pushes fit before cmd_ready drops.
      do_reset();
      for (int j = 0; j < QD + 2; j++) add_job(MB'(j), 1, 1);
      acc = 0;
      for (int k = 0; k < QD + 3; k++) begin
         @(negedge CLK);
         sample();
         s_tvalid = 1'b0;
         cmd_valid = (cmdq.size() > 0);
         if (cmd_valid) begin cmd_mem = cmdq[0].mem; cmd_len = cmdq[0].len; end
         if (cmd_valid && cmd_ready) begin void'(cmdq.pop_front()); acc++; end
      end
      @(negedge CLK);
      chk("fifo_fill_count", acc, QD + 1);
      chk("fifo_full_ready", cmd_ready, 0);
      chk("fifo_full_busy", busy, 1);
      run("fifo_order");
      chk("fifo_order_err", err, 0);

      // ---- asynchronous reset mid-LOAD ----
      do_reset();
      add_job(3'd4, 8, 8);
      for (int k = 0; k < 50 && beatq.size() > 6; k++) cycle();
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge CLK);
      cmd_valid = 1'b0; s_tvalid = 1'b0;
      clear_model();
      RST_N = 1'b1;
      @(negedge CLK);
      chk("midreset_fifo_empty", {busy, cmd_ready, s_tready}, 3'b010);

      // ---- randomized descriptors with stalls ----
      for (int b = 0; b < 3; b++) begin
         do_reset();
         stall_pct = 10 + 15 * b;
         for (int j = 0; j < 25; j++) begin
            int len, n, r;
            len = $urandom_range(0, 6);
            if ($urandom_range(9) == 0) len = $urandom_range(7, 20);
            r = $urandom_range(9);
            n = len;
            if (r >= 7 && len > 0) n = $urandom_range(1, len + 3);
            add_job(MB'($urandom_range(7)), len, n);
         end
         run($sformatf("rand%0d", b));
         chk($sformatf("rand%0d_err", b), err, exp_err);
         chk($sformatf("rand%0d_busy", b), busy, 0);
      end
      stall_pct = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
